// File: rtl/piso_pkg.sv
// piso_serializer shared helpers.
// Beat geometry and lane ordering.
package piso_pkg;

  typedef enum logic {
    SH_EMPTY = 1'b0,
    SH_FULL  = 1'b1
  } sh_state_t;

  function automatic int beats_of(
    input int dw,
    input int lanes
  );
    return dw / lanes;
  endfunction

  function automatic int cnt_width(
    input int beats
  );
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Beat k maps to this lane slot of the word.
  function automatic int lane_idx(
    input int k,
    input int beats,
    input int lsb_first
  );
    return (lsb_first != 0) ? k : beats - 1 - k;
  endfunction

endpackage

// File: rtl/piso_lane_shifter.sv
// Shifter stage: word register, beat counter,
// lane select and last-beat flag.
module piso_lane_shifter
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  sout_ready,
  output logic [LANES-1:0]      sout,
  output logic                  sout_valid,
  output logic                  sout_last,
  output logic                  free_next
);

  localparam int BEATS = beats_of(DATA_WIDTH, LANES);
  localparam int CW    = cnt_width(BEATS);

  sh_state_t             st;
  logic [DATA_WIDTH-1:0] data;
  logic [CW-1:0]         cnt;
  logic [LANES-1:0]      lane;
  logic                  at_last;
  logic                  fire;

  assign sout_valid = (st == SH_FULL);
  assign at_last    = (cnt == CW'(BEATS - 1));
  assign fire       = sout_valid & sout_ready;
  assign free_next  = ~sout_valid | (fire & at_last);
  assign sout_last  = sout_valid & at_last;
  assign sout       = sout_valid ? lane : '0;

  always_comb begin
    lane = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt == CW'(k)) begin
        lane = data[lane_idx(k, BEATS, LSB_FIRST)*LANES +: LANES];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st   <= SH_EMPTY;
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      st   <= SH_FULL;
      data <= load_data;
      cnt  <= '0;
    end else if (fire) begin
      if (at_last) begin
        st  <= SH_EMPTY;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a
// one-word hold buffer for gapless streaming.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [LANES-1:0]      sout,
  output logic                  sout_valid,
  output logic                  sout_last,
  input  logic                  sout_ready,
  output logic                  busy
);

  if (DATA_WIDTH % LANES != 0) begin : g_bad_lanes
    $error("DATA_WIDTH must be a multiple of LANES");
  end

  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  acc;
  logic                  free_next;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;

  assign din_ready = resetn & ~hold_valid;
  assign acc       = din_valid & din_ready;
  assign load      = free_next & (hold_valid | acc);
  assign load_data = hold_valid ? hold_data : din;
  assign busy      = sout_valid | hold_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (hold_valid && free_next) begin
      hold_valid <= 1'b0;
    end else if (acc && !free_next) begin
      hold_valid <= 1'b1;
      hold_data  <= din;
    end
  end

  piso_lane_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .LSB_FIRST  (LSB_FIRST)
  ) u_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .load_data  (load_data),
    .sout_ready (sout_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .free_next  (free_next)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios
// plus random traffic against a beat-queue model.
module tb_piso_serializer;

  logic        clk;
  logic        resetn;
  logic [15:0] din;
  logic        din_valid;
  logic        sout_ready;

  logic [3:0]  s_l, s_m;
  logic [15:0] s_w;
  logic v_l, v_m, v_w;
  logic l_l, l_m, l_w;
  logic r_l, r_m, r_w;
  logic b_l, b_m, b_w;

  int checks   = 0;
  int failures = 0;

  piso_serializer #(
    .DATA_WIDTH(16), .LANES(4), .LSB_FIRST(1)
  ) u_lsb (
    .clk(clk), .resetn(resetn), .din(din),
    .din_valid(din_valid), .din_ready(r_l),
    .sout(s_l), .sout_valid(v_l),
    .sout_last(l_l), .sout_ready(sout_ready),
    .busy(b_l)
  );

  piso_serializer #(
    .DATA_WIDTH(16), .LANES(4), .LSB_FIRST(0)
  ) u_msb (
    .clk(clk), .resetn(resetn), .din(din),
    .din_valid(din_valid), .din_ready(r_m),
    .sout(s_m), .sout_valid(v_m),
    .sout_last(l_m), .sout_ready(sout_ready),
    .busy(b_m)
  );

  piso_serializer #(
    .DATA_WIDTH(16), .LANES(16), .LSB_FIRST(1)
  ) u_wide (
    .clk(clk), .resetn(resetn), .din(din),
    .din_valid(din_valid), .din_ready(r_w),
    .sout(s_w), .sout_valid(v_w),
    .sout_last(l_w), .sout_ready(sout_ready),
    .busy(b_w)
  );

  logic [15:0] o_s [3];
  logic        o_v [3];
  logic        o_l [3];
  logic        o_r [3];
  logic        o_b [3];

  assign o_s[0] = {12'b0, s_l};
  assign o_s[1] = {12'b0, s_m};
  assign o_s[2] = s_w;
  assign o_v[0] = v_l;
  assign o_v[1] = v_m;
  assign o_v[2] = v_w;
  assign o_l[0] = l_l;
  assign o_l[1] = l_m;
  assign o_l[2] = l_w;
  assign o_r[0] = r_l;
  assign o_r[1] = r_m;
  assign o_r[2] = r_w;
  assign o_b[0] = b_l;
  assign o_b[1] = b_m;
  assign o_b[2] = b_w;

  // Expected beats per DUT: {last, value}.
  logic [16:0] exp_q [3][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    din_valid  = 1'b0;
    din        = '0;
    sout_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    din_valid  = 1'b1;
    din        = 16'hFFFF;
    sout_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({v_l, v_m, v_w, b_l, b_m, b_w} !== 6'b0) begin
      failures++;
      $display("FAIL reset_valid_busy got=%b exp=000000",
               {v_l, v_m, v_w, b_l, b_m, b_w});
    end
    checks++;
    if ({r_l, r_m, r_w} !== 3'b0) begin
      failures++;
      $display("FAIL reset_din_ready got=%b exp=000",
               {r_l, r_m, r_w});
    end
    checks++;
    if ({s_l, s_m, s_w, l_l, l_m, l_w} !== 27'b0) begin
      failures++;
      $display("FAIL reset_sout got=%h/%h/%h exp=0",
               s_l, s_m, s_w);
    end
    din_valid = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({r_l, r_m, r_w} !== 3'b111) begin
      failures++;
      $display("FAIL release_din_ready got=%b exp=111",
               {r_l, r_m, r_w});
    end
    tick();
  endtask

  task automatic test_order();
    logic [3:0] el [4];
    el = '{4'h3, 4'hC, 4'h5, 4'hA};
    do_reset();
    din       = 16'hA5C3;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({v_l, l_l, s_l} !== {1'b1, k == 3, el[k]}) begin
        failures++;
        $display("FAIL lsb_beat%0d got=%b/%b/%h exp=1/%b/%h",
                 k, v_l, l_l, s_l, k == 3, el[k]);
      end
      checks++;
      if ({v_m, l_m, s_m} !== {1'b1, k == 3, el[3-k]}) begin
        failures++;
        $display("FAIL msb_beat%0d got=%b/%b/%h exp=1/%b/%h",
                 k, v_m, l_m, s_m, k == 3, el[3-k]);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({v_l, v_m, s_l, s_m, b_l} !== 11'b0) begin
      failures++;
      $display("FAIL order_drain got=%b%b%h%h%b exp=0",
               v_l, v_m, s_l, s_m, b_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] el [8];
    logic [3:0] em [8];
    logic       er [8];
    el = '{4'h4, 4'h3, 4'h2, 4'h1,
           4'hD, 4'hC, 4'hB, 4'hA};
    em = '{4'h1, 4'h2, 4'h3, 4'h4,
           4'hA, 4'hB, 4'hC, 4'hD};
    er = '{1'b1, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    din       = 16'h1234;
    din_valid = 1'b1;
    tick();
    din = 16'hABCD;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ({v_l, l_l, s_l} !== {1'b1, c == 3 || c == 7, el[c]}) begin
        failures++;
        $display("FAIL b2b_lsb%0d got=%b/%b/%h exp=%h",
                 c, v_l, l_l, s_l, el[c]);
      end
      checks++;
      if ({v_m, s_m} !== {1'b1, em[c]}) begin
        failures++;
        $display("FAIL b2b_msb%0d got=%b/%h exp=%h",
                 c, v_m, s_m, em[c]);
      end
      checks++;
      if (r_l !== er[c]) begin
        failures++;
        $display("FAIL b2b_ready%0d got=%b exp=%b",
                 c, r_l, er[c]);
      end
      tick();
      din_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({v_l, b_l} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_drain got=%b%b exp=00", v_l, b_l);
    end
  endtask

  task automatic test_stall();
    logic [3:0] el [7];
    el = '{4'h3, 4'hC, 4'hC, 4'hC, 4'hC, 4'h5, 4'hA};
    do_reset();
    din       = 16'hA5C3;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if ({v_l, l_l, s_l} !== {1'b1, c == 6, el[c]}) begin
        failures++;
        $display("FAIL stall_c%0d got=%b/%b/%h exp=1/%b/%h",
                 c, v_l, l_l, s_l, c == 6, el[c]);
      end
      tick();
      sout_ready = !(c >= 0 && c < 3);
    end
    sout_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    din       = 16'h1234;
    din_valid = 1'b1;
    tick();
    din = 16'hABCD;
    tick();
    din_valid = 1'b0;
    tick();
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({v_l, s_l, b_l, r_l} !== {1'b1, 4'h2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mid_pre got=%b/%h/%b/%b exp=1/2/1/0",
               v_l, s_l, b_l, r_l);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({v_l, b_l, v_m, b_m, s_l} !== 8'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b%b%b%b/%h exp=0",
               v_l, b_l, v_m, b_m, s_l);
    end
    resetn = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({r_l, v_l, b_l, s_l} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
        failures++;
        $display("FAIL mid_stale%0d got=%b%b%b/%h exp=100/0",
                 c, r_l, v_l, b_l, s_l);
      end
      tick();
    end
  endtask

  task automatic test_wide();
    do_reset();
    din       = 16'h0001;
    din_valid = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) din = 16'(c + 2);
      else din_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({v_w, l_w, s_w} !== {1'b1, 1'b1, 16'(c + 1)}) begin
        failures++;
        $display("FAIL wide_w%0d got=%b/%b/%h exp=1/1/%h",
                 c, v_w, l_w, s_w, 16'(c + 1));
      end
      checks++;
      if (r_w !== 1'b1) begin
        failures++;
        $display("FAIL wide_ready%0d got=%b exp=1", c, r_w);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({v_w, b_w, s_w} !== 18'b0) begin
      failures++;
      $display("FAIL wide_drain got=%b%b/%h exp=0",
               v_w, b_w, s_w);
    end
  endtask

  task automatic test_random();
    int          nb;
    logic        ev;
    logic [16:0] eb;
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    for (int c = 0; c < 600; c++) begin
      din        = 16'($urandom);
      din_valid  = ($urandom_range(0, 3) != 0);
      sout_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        nb = (i == 2) ? 1 : 4;
        ev = (exp_q[i].size() != 0);
        eb = ev ? exp_q[i][0] : 17'b0;
        checks++;
        if (o_v[i] !== ev || o_b[i] !== ev) begin
          failures++;
          $display("FAIL rnd_valid d%0d c%0d got=%b%b exp=%b",
                   i, c, o_v[i], o_b[i], ev);
        end
        checks++;
        if ({o_l[i], o_s[i]} !== eb) begin
          failures++;
          $display("FAIL rnd_beat d%0d c%0d got=%b/%h exp=%b/%h",
                   i, c, o_l[i], o_s[i], eb[16], eb[15:0]);
        end
        checks++;
        if (o_r[i] !== (exp_q[i].size() <= nb)) begin
          failures++;
          $display("FAIL rnd_ready d%0d c%0d got=%b exp=%b",
                   i, c, o_r[i], exp_q[i].size() <= nb);
        end
        if (ev && sout_ready) void'(exp_q[i].pop_front());
        if (din_valid && exp_q[i].size() + 1 <= nb + (ev && sout_ready ? 1 : 0)) begin
          // no-op: acceptance decided below from the model state
        end
      end
      for (int i = 0; i < 3; i++) begin
        nb = (i == 2) ? 1 : 4;
        w  = din;
        if (din_valid && o_r[i] === 1'b1) begin
          for (int k = 0; k < nb; k++) begin
            if (i == 0)
              exp_q[i].push_back({k == 3, 12'b0, 4'(w >> (4*k))});
            else if (i == 1)
              exp_q[i].push_back({k == 3, 12'b0, 4'(w >> (12 - 4*k))});
            else
              exp_q[i].push_back({1'b1, w});
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    resetn     = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    sout_ready = 1'b1;
    test_reset();
    test_order();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_wide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: parallel word width in bits.
REQ-002 SHALL have parameter LANES, default 1: serial bits per beat; DATA_WIDTH % LANES == 0 required, elaboration error otherwise.
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 = least-significant lane first, 0 = most-significant lane first.
REQ-004 SHALL have port clk  input  1: rising-edge clock for all state.
REQ-005 SHALL have port resetn  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port din  input  DATA_WIDTH: parallel word to serialize.
REQ-007 SHALL have port din_valid  input  1: din is valid this cycle.
REQ-008 SHALL have port din_ready  output  1: word accepted when din_valid & din_ready.
REQ-009 SHALL have port sout  output  LANES: current serial beat.
REQ-010 SHALL have port sout_valid  output  1: sout is valid.
REQ-011 SHALL have port sout_last  output  1: current beat is the final beat of its word.
REQ-012 SHALL have port sout_ready  input  1: beat consumed when sout_valid & sout_ready.
REQ-013 SHALL have port busy  output  1: shifter or hold buffer holds data.

Function
REQ-014 SHALL define BEATS = DATA_WIDTH/LANES and a beat counter of width max(1,clog2(BEATS)), wrapping from BEATS-1 to 0.
REQ-015 SHALL contain a shifter (data, valid, beat count) and a one-word hold buffer (data, valid); din_ready = resetn & ~hold_valid.
REQ-016 Shifter "free next" SHALL mean: shifter empty, or last beat consumed this cycle.
REQ-017 Accepted word SHALL load directly into shifter if free next and hold empty; otherwise into hold buffer.
REQ-018 When shifter free next and hold valid, hold word SHALL move into shifter and hold_valid clear in the same edge.
REQ-019 Latency: word accepted at edge N SHALL present beat 0 on sout in cycle N+1 when shifter free next.
REQ-020 LSB_FIRST=1: beat k SHALL equal din[k*LANES +: LANES]; LSB_FIRST=0: beat k SHALL equal din[DATA_WIDTH-1-k*LANES -: LANES].
REQ-021 sout_last SHALL assert iff sout_valid and beat count == BEATS-1; with BEATS==1 every beat is last.
REQ-022 sout, sout_last SHALL hold stable while sout_valid & ~sout_ready.
REQ-023 sout and sout_last SHALL be 0 whenever sout_valid is 0.
REQ-024 With continuous din_valid and sout_ready, beats SHALL stream with no bubble between words, including BEATS==1 (one word per cycle).
REQ-025 Last beat consumed with hold empty and no new accept: sout_valid SHALL drop next cycle.
REQ-026 busy SHALL equal sout_valid | hold_valid.

Reset
REQ-027 resetn low at an edge SHALL clear shifter valid/data, beat count, hold valid/data; sout, sout_valid, sout_last, busy = 0 next cycle.
REQ-028 din_ready SHALL be 0 while resetn low; in-flight and held words discarded, no partial beats after release.

Structure
REQ-029 Package piso_pkg SHALL hold the beats/counter-width helper function and the lane-index helper; no enum needed beyond shifter valid.
REQ-030 One sub-module piso_lane_shifter SHALL implement shifter data, beat counter, lane select and last flag; top holds hold buffer and handshake.

Verification
REQ-031 DW=16,LANES=4,LSB_FIRST=1, din=0xA5C3, sout_ready=1 -> sout 3,C,5,A on 4 consecutive cycles, sout_last only on A.
REQ-032 Same with LSB_FIRST=0 -> sout A,5,C,3, sout_last on 3.
REQ-033 Back-to-back 0x1234, 0xABCD, sout_ready=1 -> 8 contiguous beats 4,3,2,1,D,C,B,A; din_ready low from cycle after 2nd accept until hold drains.
REQ-034 sout_ready low 3 cycles at beat 1 of 0xA5C3 -> sout held 0xC, sout_valid 1, then resumes 5,A.
REQ-035 resetn low during beat 2 with hold full -> next cycle sout_valid=0, busy=0; after release din_ready=1, no stale beats.
REQ-036 LANES=16 (BEATS=1), 4 words 0x0001..0x0004 continuous -> one word per cycle, sout_last=1 each beat.
